// File: rtl/sync_pkg.sv
// rtl/sync_pkg.sv - shared types and helpers for input conditioner blocks
`timescale 1ns/1ps
package sync_pkg;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

  function automatic int cnt_w(int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one channel: sync chain, debounce counter, level and edge registers
`timescale 1ns/1ps
module debounce_channel
  import sync_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter int   DEBOUNCE  = 3,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = cnt_w(DEBOUNCE);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [STAGES-1:0] sync_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              level_q, level_d;
  edge_t             pulse_q, pulse_d;
  logic              sync_s;

  assign sync_s = sync_q[STAGES-1];

  // Pure shift chain: nothing combinational between the metastability flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in_i};
    end
  end

  // A differing level must persist DEBOUNCE consecutive cycles; any agreement restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = '0;
    if (sync_s != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d       = sync_s;
        pulse_d.rise  = sync_s;
        pulse_d.fall  = ~sync_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= RESET_VAL;
      pulse_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign out_o  = level_q;
  assign rise_o = pulse_q.rise;
  assign fall_o = pulse_q.fall;

endmodule

// File: rtl/synchronizer_debounce.sv
// rtl/synchronizer_debounce.sv - N-channel synchronizer with debounce filter and edge pulses
`timescale 1ns/1ps
module synchronizer_debounce
  import sync_pkg::*;
#(
  parameter int   N         = 4,
  parameter int   STAGES    = 2,
  parameter int   DEBOUNCE  = 3,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_d,
  output logic [N-1:0] out_q,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .STAGES   (STAGES),
      .DEBOUNCE (DEBOUNCE),
      .RESET_VAL(RESET_VAL)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .in_i  (in_d[i]),
      .out_o (out_q[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i])
    );
  end

endmodule

// File: tb/tb_synchronizer_debounce.sv
// tb/tb_synchronizer_debounce.sv - scoreboard bench with windowed reference model
`timescale 1ns/1ps
module tb_synchronizer_debounce;

  localparam int N        = 4;
  localparam int STAGES   = 2;
  localparam int DEBOUNCE = 3;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] in_d  = '0;
  logic [N-1:0] out_q, rise, fall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] o;
    logic [N-1:0] r;
    logic [N-1:0] f;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] hist[$];
  logic [N-1:0] m_out;
  logic [N-1:0] m_nxt;
  logic         all_diff;
  int           rise2_cnt = 0;
  int           fall2_cnt = 0;

  synchronizer_debounce #(
    .N(N), .STAGES(STAGES), .DEBOUNCE(DEBOUNCE), .RESET_VAL(1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .in_d (in_d),
    .out_q(out_q),
    .rise (rise),
    .fall (fall)
  );

  always #50 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a channel flips when the last DEBOUNCE post-sync samples all disagree with its level.
  // hist[0] is the raw input seen at the previous edge; the sync output used now is STAGES edges old.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      for (int k = 0; k < STAGES + DEBOUNCE; k++) hist.push_back('0);
      m_out = '0;
      sb.delete();
    end else begin
      m_nxt = m_out;
      for (int ch = 0; ch < N; ch++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DEBOUNCE; j++)
          if (hist[STAGES-1+j][ch] == m_out[ch]) all_diff = 1'b0;
        if (all_diff) m_nxt[ch] = ~m_out[ch];
      end
      hist.push_front(in_d);
      void'(hist.pop_back());
      sb.push_back('{o: m_nxt, r: m_nxt & ~m_out, f: ~m_nxt & m_out});
      m_out = m_nxt;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_out_q", out_q, e.o);
      check("sb_rise", rise, e.r);
      check("sb_fall", fall, e.f);
      check("sb_rise_fall_excl", rise & fall, '0);
    end
    if (!reset) begin
      if (rise[2]) rise2_cnt++;
      if (fall[2]) fall2_cnt++;
    end
  end

  initial begin
    int edges;
    int r0, f0;
    int prob;

    // 1: reset while inputs high
    repeat (2) @(negedge clk);
    reset = 1'b0;
    in_d  = 4'hF;
    repeat (8) @(negedge clk);
    check("pre_reset_out_q", out_q, 4'hF);
    #10 reset = 1'b1;
    #1;
    check("reset_out_q", out_q, '0);
    check("reset_rise", rise, '0);
    check("reset_fall", fall, '0);
    in_d = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 2: rising step
    in_d = 4'b0101;
    repeat (4) @(posedge clk);
    #1 check("step_rise_edge4_out_q", out_q, 4'b0000);
    @(posedge clk);
    #1 check("step_rise_edge5_out_q", out_q, 4'b0101);
    check("step_rise_edge5_rise", rise, 4'b0101);
    check("step_rise_edge5_fall", fall, 4'b0000);
    @(posedge clk);
    #1 check("step_rise_edge6_rise", rise, 4'b0000);
    repeat (3) @(negedge clk);

    // 4: falling step
    in_d = 4'b0000;
    repeat (4) @(posedge clk);
    #1 check("step_fall_edge4_fall", fall, 4'b0000);
    @(posedge clk);
    #1 check("step_fall_edge5_fall", fall, 4'b0101);
    check("step_fall_edge5_rise", rise, 4'b0000);
    check("step_fall_edge5_out_q", out_q, 4'b0000);
    repeat (3) @(negedge clk);

    // 3: two-cycle glitch on channel 0
    in_d[0] = 1'b1;
    repeat (2) @(negedge clk);
    in_d[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 check("glitch_out_q", out_q, '0);
      check("glitch_pulses", rise | fall, '0);
    end
    @(negedge clk);

    // 5: reset one cycle after the synchronized level rises
    in_d[3] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1 check("midcount_reset_out_q", out_q, '0);
    @(negedge clk);
    reset = 1'b0;
    edges = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (out_q[3]) begin
        edges = e;
        break;
      end
    end
    check("midcount_latency", 4'(edges), 4'd5);
    @(negedge clk);
    in_d = '0;
    repeat (8) @(negedge clk);

    // 6: chatter on channel 2, last toggle to 1
    r0 = rise2_cnt;
    f0 = fall2_cnt;
    for (int k = 0; k < 8; k++) begin
      in_d[2] = ~in_d[2];
      @(negedge clk);
    end
    in_d[2] = 1'b1;
    edges = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (out_q[2]) begin
        edges = e;
        break;
      end
    end
    check("chatter_latency", 4'(edges), 4'd5);
    repeat (4) @(negedge clk);
    check("chatter_rise_count", 4'(rise2_cnt - r0), 4'd1);
    check("chatter_fall_count", 4'(fall2_cnt - f0), 4'd0);

    // randomized phase: alternating calm and noisy stretches, one reset in the middle
    prob = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i % 50 == 0) prob = ($urandom_range(0, 1) == 0) ? 1 : 8;
      if (i == 200) reset = 1'b1;
      if (i == 202) reset = 1'b0;
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, prob) == 0) in_d[ch] = ~in_d[ch];
    end
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
